// File: rtl/pc_ir_if.sv
// Fetch-side bundle between the control FSM/ALU/instruction memory and the PC/IR unit.
// The master drives strobes and ALU/memory data; the slave returns the architectural registers.
interface pc_ir_if #(
    parameter int XLEN = 32
);
    logic            pc_write;
    logic            pc_write_cond;
    logic            pc_source;
    logic            ir_write;
    logic [XLEN-1:0] alu_result;
    logic            alu_zero;
    logic            alu_neg;
    logic            alu_ovf;
    logic            alu_carry;
    logic [31:0]     mem_rdata;

    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] old_pc;
    logic [31:0]     instr;
    logic [6:0]      instruction_opcode;
    logic [XLEN-1:0] alu_out;
    logic            branch_taken;
    logic            misaligned;
    logic [31:0]     instret;

    modport master (
        output pc_write, pc_write_cond, pc_source, ir_write,
        output alu_result, alu_zero, alu_neg, alu_ovf, alu_carry, mem_rdata,
        input  pc, old_pc, instr, instruction_opcode, alu_out,
        input  branch_taken, misaligned, instret
    );

    modport slave (
        input  pc_write, pc_write_cond, pc_source, ir_write,
        input  alu_result, alu_zero, alu_neg, alu_ovf, alu_carry, mem_rdata,
        output pc, old_pc, instr, instruction_opcode, alu_out,
        output branch_taken, misaligned, instret
    );
endinterface

// File: rtl/pc_ir_unit.sv
// Multicycle fetch-side registers: PC, OldPC, IR, ALUOut, retired-instruction count,
// plus the branch-condition evaluation fed back to the control FSM.
module pc_ir_unit #(
    parameter int              XLEN         = 32,
    parameter logic [XLEN-1:0] RESET_VECTOR = '0
) (
    input  logic  clk,
    input  logic  rst_n,
    pc_ir_if.slave bus
);
    typedef enum logic [2:0] {
        F3_BEQ  = 3'b000,
        F3_BNE  = 3'b001,
        F3_BLT  = 3'b100,
        F3_BGE  = 3'b101,
        F3_BLTU = 3'b110,
        F3_BGEU = 3'b111
    } branch_f3_e;

    logic [XLEN-1:0] pc_q;
    logic [XLEN-1:0] old_pc_q;
    logic [XLEN-1:0] alu_out_q;
    logic [31:0]     instr_q;
    logic [31:0]     instret_q;
    logic            misaligned_q;

    logic            taken;
    logic            pc_update;
    logic [XLEN-1:0] target;

    // NOTE: every variable written in always_comb gets a default first, so no path infers a latch.
    always_comb begin
        taken = 1'b0;
        case (instr_q[14:12])
            F3_BEQ:  taken = bus.alu_zero;
            F3_BNE:  taken = !bus.alu_zero;
            F3_BLT:  taken = bus.alu_neg ^ bus.alu_ovf;
            F3_BGE:  taken = !(bus.alu_neg ^ bus.alu_ovf);
            F3_BLTU: taken = !bus.alu_carry;
            F3_BGEU: taken = bus.alu_carry;
            default: taken = 1'b0;
        endcase
    end

    // pc_write dominates; the conditional strobe only matters on its own.
    assign pc_update = bus.pc_write || (bus.pc_write_cond && taken);
    assign target    = bus.pc_source ? alu_out_q : bus.alu_result;

    // NOTE: sequential state uses non-blocking assignments so all registers sample pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q         <= RESET_VECTOR;
            old_pc_q     <= '0;
            alu_out_q    <= '0;
            instr_q      <= '0;
            instret_q    <= '0;
            misaligned_q <= 1'b0;
        end else begin
            alu_out_q <= bus.alu_result;
            if (pc_update) begin
                pc_q <= {target[XLEN-1:2], 2'b00};
                if (target[1:0] != 2'b00) begin
                    misaligned_q <= 1'b1;
                end
            end
            // old_pc captures the pre-edge PC even when a FETCH also advances pc.
            if (bus.ir_write) begin
                instr_q   <= bus.mem_rdata;
                old_pc_q  <= pc_q;
                instret_q <= instret_q + 32'd1;
            end
        end
    end

    assign bus.pc                 = pc_q;
    assign bus.old_pc             = old_pc_q;
    assign bus.instr              = instr_q;
    assign bus.instruction_opcode = instr_q[6:0];
    assign bus.alu_out            = alu_out_q;
    assign bus.branch_taken       = taken;
    assign bus.misaligned         = misaligned_q;
    assign bus.instret            = instret_q;
endmodule
